// File: rtl/tpum_row_loader.sv
// TPUM operand row loader: pipelined XBOX beat fetch into one row register.
// Define TPUM_ROW_LOADER_ERR_EN to add xbox_rd_rsp_err / row_err reporting.
module tpum_row_loader #(
  parameter int DATA_W  = 32,
  parameter int ROW_W   = 1024,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [ADDR_W-1:0] load_base,
  output logic              xbox_rd_req_valid,
  input  logic              xbox_rd_req_ready,
  output logic [ADDR_W-1:0] xbox_rd_addr,
  input  logic              xbox_rd_rsp_valid,
  output logic              xbox_rd_rsp_ready,
  input  logic [DATA_W-1:0] xbox_rd_rsp_data,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              row_sel,
  output logic [ROW_W-1:0]  row_data,
  output logic              busy
`ifdef TPUM_ROW_LOADER_ERR_EN
  ,
  input  logic              xbox_rd_rsp_err,
  output logic              row_err
`endif
);

  localparam int BEATS = ROW_W / DATA_W;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int OW    = $clog2(MAX_OUT + 1);
  localparam int BSH   = $clog2(DATA_W / 8);

  localparam logic [ADDR_W-1:0] AMASK =
    {ADDR_W{1'b1}} << BSH;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     req_cnt_q;
  logic [CW-1:0]     rsp_cnt_q;
  logic [OW-1:0]     out_q;
  logic [ADDR_W-1:0] base_q;
  logic              sel_q;
  logic [ROW_W-1:0]  row_q;

  logic req_hs;
  logic rsp_hs;
  logic last_rsp;

  assign xbox_rd_req_valid = (state_q == FETCH)
                          && (req_cnt_q < CW'(BEATS))
                          && (out_q < OW'(MAX_OUT));

  assign xbox_rd_addr = base_q
                      + (ADDR_W'(req_cnt_q) << BSH);

  assign xbox_rd_rsp_ready = (state_q == FETCH);

  assign req_hs   = xbox_rd_req_valid && xbox_rd_req_ready;
  assign rsp_hs   = xbox_rd_rsp_valid && xbox_rd_rsp_ready;
  assign last_rsp = rsp_hs && (rsp_cnt_q == CW'(BEATS - 1));

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign row_valid  = (state_q == HOLD);
  assign row_sel    = sel_q;
  assign row_data   = row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      out_q     <= '0;
      base_q    <= '0;
      sel_q     <= 1'b0;
      row_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            sel_q     <= load_sel;
            base_q    <= load_base & AMASK;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            out_q     <= '0;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          if (req_hs) begin
            req_cnt_q <= req_cnt_q + CW'(1);
          end
          if (rsp_hs) begin
            for (int b = 0; b < BEATS; b++) begin
              if (rsp_cnt_q == CW'(b)) begin
                row_q[b*DATA_W +: DATA_W] <= xbox_rd_rsp_data;
              end
            end
            rsp_cnt_q <= rsp_cnt_q + CW'(1);
          end
          // Simultaneous request and response leave the count unchanged.
          if (req_hs && !rsp_hs) begin
            out_q <= out_q + OW'(1);
          end else if (!req_hs && rsp_hs) begin
            out_q <= out_q - OW'(1);
          end
          if (last_rsp) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (row_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef TPUM_ROW_LOADER_ERR_EN
  logic err_q;

  assign row_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == HOLD && row_ready) begin
      err_q <= 1'b0;
    end else if (rsp_hs && xbox_rd_rsp_err) begin
      err_q <= 1'b1;
    end
  end
`endif

endmodule
